dmi_handler: RTL and testbench
==============================

Name: dmi_handler

Overview:
- Sits directly downstream of the UART DMI TAP and bridges its level-style DMI_READ/DMI_WRITE strobes to the Debug Module's valid/ready DMI request and response channels.
- Builds the dmi_req_t, performs both handshakes, and returns the dmi_resp_t with a single-cycle DONE pulse.
- Guards against a hung DM with a timeout.
- Keeps a sticky 2-bit error code that the TAP reflects into dtmcs.dmistat.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles allowed in REQ+RESP before abort; must be >= 2.
- ADDR_W, 7, DMI address width (dmi_req_t.addr).

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  asynchronous active-high reset
- DMI_HARD_RESET_I  in  1  from TAP dtmcs.dmihardreset; aborts any operation and clears error
- DMI_READ_I  in  1  TAP read request, held high until DONE seen
- DMI_WRITE_I  in  1  TAP write request, held high until DONE seen
- DMI_I  in  41  TAP request {addr[40:34], op[33:32], data[31:0]}
- DMI_O  out  41  response to TAP: [33:0] = {data[33:2], resp[1:0]}, [40:34] = 0
- DMI_DONE_O  out  1  one-cycle completion pulse
- DMI_ERROR_O  out  2  sticky error: 00 none, 10 failed, 11 busy/timeout
- DMI_REQ_O  out  41  request to DM
- DMI_REQ_VALID_O  out  1  request valid
- DMI_REQ_READY_I  in  1  DM accepts request
- DMI_RESP_I  in  34  DM response {data[33:2], resp[1:0]}
- DMI_RESP_VALID_I  in  1  response valid
- DMI_RESP_READY_O  out  1  handler accepts response

Behaviour:
- All outputs are registered.
- Reset (RST_I high, async): state IDLE; DMI_O = 0, DMI_DONE_O = 0, DMI_ERROR_O = 00, DMI_REQ_O = 0, DMI_REQ_VALID_O = 0, DMI_RESP_READY_O = 0, timer = 0.
- States: IDLE, REQ, RESP, DONE, RELEASE.
- IDLE:
  - On DMI_WRITE_I or DMI_READ_I, latch DMI_REQ_O.addr = DMI_I[40:34].
  - Write: op = 2'b10, data = DMI_I[31:0]. Read: op = 2'b01, data = 0. The TAP's op field is ignored.
  - If both strobes are high, WRITE wins.
  - Set DMI_REQ_VALID_O = 1 and go to REQ. Request is visible one cycle after the strobe is sampled.
- REQ:
  - Hold DMI_REQ_O stable while VALID is high.
  - On VALID & REQ_READY_I: VALID <= 0, RESP_READY_O <= 1, go to RESP.
- RESP:
  - On RESP_VALID_I & RESP_READY_O: latch DMI_O[33:0] = DMI_RESP_I, RESP_READY_O <= 0, go to DONE.
  - If resp == 2'b10, DMI_ERROR_O <= 10 unless it is already 11.
  - resp == 2'b11 from the DM sets DMI_ERROR_O <= 11.
- DONE: DMI_DONE_O = 1 for exactly this one cycle; go to RELEASE.
  - Minimum strobe-to-DONE latency is 3 cycles, with REQ_READY and RESP_VALID both already high.
- RELEASE: wait until DMI_READ_I = 0 and DMI_WRITE_I = 0, then go to IDLE. This prevents a re-issue while the TAP drops its strobe.
- Timer:
  - Counts every cycle in REQ or RESP; cleared in all other states.
  - When the timer reaches TIMEOUT_CYCLES-1: VALID <= 0, RESP_READY_O <= 0, DMI_O[1:0] <= 11, DMI_O[33:2] <= 0, DMI_ERROR_O <= 11, go to DONE (the TAP still receives DONE).
  - A handshake completing in the same cycle as the timeout wins; no error is set.
- Strobe withdrawn mid-operation (both low in REQ or RESP): the operation is not cancelled. It completes, DONE still pulses, then RELEASE immediately returns to IDLE.
- DMI_HARD_RESET_I (synchronous, highest priority after RST_I):
  - Forces IDLE and clears VALID, RESP_READY_O, timer and DMI_ERROR_O to 00. DMI_O is held.
  - No DONE pulse is produced.
  - New strobes are ignored while it is high.
- DMI_ERROR_O stays sticky until RST_I or DMI_HARD_RESET_I; 11 is never downgraded to 10.

Test Plan:
- Read: DMI_I addr = 0x11, DMI_READ_I held; DM READY = 1, RESP = {0xDEADBEEF, 00} one cycle later -> DMI_REQ_O op = 01, addr = 0x11; single DONE; DMI_O[33:0] = {0xDEADBEEF, 00}; ERROR = 00; no second request while READ stays high.
- Write: DMI_I = {0x10, xx, 0x00000001}, WRITE held; REQ_READY delayed 5 cycles -> DMI_REQ_O stable with op = 10, data = 0x1, for all 5 cycles; DONE once after the response.
- Timeout: TIMEOUT_CYCLES = 16, REQ_READY tied 0 -> VALID drops after 16 cycles in REQ; DONE pulses; DMI_O[1:0] = 11; ERROR = 11, still 11 after a subsequent successful read.
- Failed response: DM returns resp = 10 -> ERROR = 10; DMI_HARD_RESET_I pulse -> ERROR = 00.
- Hard reset mid-RESP: assert DMI_HARD_RESET_I while waiting on RESP_VALID -> RESP_READY_O = 0 next cycle; no DONE; handler in IDLE and accepts the next READ.
- Simultaneous READ and WRITE in IDLE -> op = 10 issued; async RST_I mid-REQ -> VALID = 0 immediately, no clock needed.

Source files
------------

// File: rtl/dmi_handler.sv
`default_nettype none
// ============================================================================
// Module   : dmi_handler
// Purpose  : Bridges TAP DMI read/write strobes to the DM valid/ready request
//            and response channels, with timeout and sticky error status.
// Revision : 1.0
// ============================================================================
module dmi_handler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 7
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                DMI_HARD_RESET_I,
    input  logic                DMI_READ_I,
    input  logic                DMI_WRITE_I,
    input  logic [ADDR_W+33:0]  DMI_I,
    output logic [ADDR_W+33:0]  DMI_O,
    output logic                DMI_DONE_O,
    output logic [1:0]          DMI_ERROR_O,
    output logic [ADDR_W+33:0]  DMI_REQ_O,
    output logic                DMI_REQ_VALID_O,
    input  logic                DMI_REQ_READY_I,
    input  logic [33:0]         DMI_RESP_I,
    input  logic                DMI_RESP_VALID_I,
    output logic                DMI_RESP_READY_O
);

    localparam int              c_TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0] c_TIMER_MAX = c_TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_REQ     = 3'd1;
    localparam logic [2:0] c_ST_RESP    = 3'd2;
    localparam logic [2:0] c_ST_DONE    = 3'd3;
    localparam logic [2:0] c_ST_RELEASE = 3'd4;

    logic [2:0]      r_state;
    logic [c_TW-1:0] r_timer;

    logic w_strobe;
    logic w_req_hs;
    logic w_resp_hs;
    logic w_timeout;
    logic w_unused;

    assign w_strobe  = DMI_READ_I | DMI_WRITE_I;
    assign w_req_hs  = DMI_REQ_VALID_O & DMI_REQ_READY_I;
    assign w_resp_hs = DMI_RESP_VALID_I & DMI_RESP_READY_O;
    // Timer saturates at the limit, so the REQ+RESP budget is shared.
    assign w_timeout = (r_timer == c_TIMER_MAX);
    assign w_unused  = ^DMI_I[33:32];

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state          <= c_ST_IDLE;
            r_timer          <= '0;
            DMI_O            <= '0;
            DMI_DONE_O       <= 1'b0;
            DMI_ERROR_O      <= 2'b00;
            DMI_REQ_O        <= '0;
            DMI_REQ_VALID_O  <= 1'b0;
            DMI_RESP_READY_O <= 1'b0;
        end else if (DMI_HARD_RESET_I) begin
            r_state          <= c_ST_IDLE;
            r_timer          <= '0;
            DMI_DONE_O       <= 1'b0;
            DMI_ERROR_O      <= 2'b00;
            DMI_REQ_VALID_O  <= 1'b0;
            DMI_RESP_READY_O <= 1'b0;
        end else begin
            DMI_DONE_O <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_timer <= '0;
                    if (w_strobe) begin
                        DMI_REQ_O <= {DMI_I[ADDR_W+33:34],
                                      DMI_WRITE_I ? 2'b10 : 2'b01,
                                      DMI_WRITE_I ? DMI_I[31:0] : 32'h0};
                        DMI_REQ_VALID_O <= 1'b1;
                        r_state         <= c_ST_REQ;
                    end
                end
                c_ST_REQ, c_ST_RESP: begin
                    if (!w_timeout) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    if (r_state == c_ST_REQ && w_req_hs) begin
                        DMI_REQ_VALID_O  <= 1'b0;
                        DMI_RESP_READY_O <= 1'b1;
                        r_state          <= c_ST_RESP;
                    end else if (r_state == c_ST_RESP && w_resp_hs) begin
                        DMI_O            <= {{ADDR_W{1'b0}}, DMI_RESP_I};
                        DMI_RESP_READY_O <= 1'b0;
                        DMI_DONE_O       <= 1'b1;
                        r_state          <= c_ST_DONE;
                        if (DMI_RESP_I[1:0] == 2'b11) begin
                            DMI_ERROR_O <= 2'b11;
                        end else if (DMI_RESP_I[1:0] == 2'b10 && DMI_ERROR_O != 2'b11) begin
                            DMI_ERROR_O <= 2'b10;
                        end
                    end else if (w_timeout) begin
                        DMI_REQ_VALID_O  <= 1'b0;
                        DMI_RESP_READY_O <= 1'b0;
                        DMI_O            <= {{ADDR_W{1'b0}}, 32'h0, 2'b11};
                        DMI_ERROR_O      <= 2'b11;
                        DMI_DONE_O       <= 1'b1;
                        r_state          <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_timer <= '0;
                    r_state <= c_ST_RELEASE;
                end
                c_ST_RELEASE: begin
                    r_timer <= '0;
                    if (!w_strobe) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmi_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_handler
// Purpose  : Directed self-checking bench for dmi_handler.
// Revision : 1.0
// ============================================================================
module tb_dmi_handler;

    localparam int T = 16;

    logic        clk;
    logic        rst;
    logic        hard;
    logic        rd;
    logic        wr;
    logic [40:0] dmi_in;
    logic [40:0] dmi_out;
    logic        done;
    logic [1:0]  err;
    logic [40:0] req;
    logic        req_valid;
    logic        req_ready;
    logic [33:0] resp;
    logic        resp_valid;
    logic        resp_ready;

    int n_vec = 0;
    int n_err = 0;

    dmi_handler #(.TIMEOUT_CYCLES(T), .ADDR_W(7)) dut (
        .CLK_I            (clk),
        .RST_I            (rst),
        .DMI_HARD_RESET_I (hard),
        .DMI_READ_I       (rd),
        .DMI_WRITE_I      (wr),
        .DMI_I            (dmi_in),
        .DMI_O            (dmi_out),
        .DMI_DONE_O       (done),
        .DMI_ERROR_O      (err),
        .DMI_REQ_O        (req),
        .DMI_REQ_VALID_O  (req_valid),
        .DMI_REQ_READY_I  (req_ready),
        .DMI_RESP_I       (resp),
        .DMI_RESP_VALID_I (resp_valid),
        .DMI_RESP_READY_O (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation against an always-ready DM and returns whether DONE was seen.
    task automatic run_op(input logic is_wr, input logic [40:0] r, input logic [33:0] rs,
                          output logic got_done);
        dmi_in = r; wr = is_wr; rd = !is_wr;
        req_ready = 1'b1; resp_valid = 1'b1; resp = rs;
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            tick();
            if (done) got_done = 1'b1;
        end
        rd = 1'b0; wr = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        if (dmi_out !== 41'h0) begin n_err++; $display("FAIL reset_dmi_o: got %h expected 0", dmi_out); end
        n_vec++;
        if ({done, err, req_valid, resp_ready} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 00000", {done, err, req_valid, resp_ready});
        end
        n_vec++;
        if (req !== 41'h0) begin n_err++; $display("FAIL reset_req: got %h expected 0", req); end
        n_vec++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read;
        int extra;
        dmi_in = {7'h11, 2'b11, 32'h1234_5678};
        rd = 1'b1; req_ready = 1'b1; resp_valid = 1'b0;
        tick();
        if ({req_valid, req} !== {1'b1, 7'h11, 2'b01, 32'h0}) begin
            n_err++; $display("FAIL read_req: got %b/%h expected 1/%h", req_valid, req, {7'h11, 2'b01, 32'h0});
        end
        n_vec++;
        tick();
        if ({req_valid, resp_ready} !== 2'b01) begin
            n_err++; $display("FAIL read_resp_ready: got %b expected 01", {req_valid, resp_ready});
        end
        n_vec++;
        resp_valid = 1'b1; resp = {32'hDEAD_BEEF, 2'b00};
        tick();
        if ({done, err} !== 3'b100) begin n_err++; $display("FAIL read_done: got %b expected 100", {done, err}); end
        n_vec++;
        if (dmi_out !== {7'h0, 32'hDEAD_BEEF, 2'b00}) begin
            n_err++; $display("FAIL read_data: got %h expected %h", dmi_out, {7'h0, 32'hDEAD_BEEF, 2'b00});
        end
        n_vec++;
        resp_valid = 1'b0;
        extra = 0;
        repeat (6) begin
            tick();
            if (done || req_valid) extra++;
        end
        if (extra !== 0) begin n_err++; $display("FAIL read_no_reissue: got %0d extra expected 0", extra); end
        n_vec++;
        rd = 1'b0; req_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_write;
        int dones;
        dmi_in = {7'h10, 2'b00, 32'h0000_0001};
        wr = 1'b1; req_ready = 1'b0; resp_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if ({req_valid, req} !== {1'b1, 7'h10, 2'b10, 32'h1}) begin
                n_err++; $display("FAIL write_req_stable[%0d]: got %b/%h expected 1/%h", i, req_valid, req,
                                  {7'h10, 2'b10, 32'h1});
            end
            n_vec++;
            if (i < 4) tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0; resp_valid = 1'b1; resp = {32'h55AA_0001, 2'b00};
        dones = 0;
        repeat (4) begin
            tick();
            if (done) dones++;
        end
        if (dones !== 1) begin n_err++; $display("FAIL write_done_count: got %0d expected 1", dones); end
        n_vec++;
        if (dmi_out !== {7'h0, 32'h55AA_0001, 2'b00}) begin
            n_err++; $display("FAIL write_data: got %h expected %h", dmi_out, {7'h0, 32'h55AA_0001, 2'b00});
        end
        n_vec++;
        wr = 1'b0; resp_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_simultaneous_async_reset;
        dmi_in = {7'h22, 2'b00, 32'hA5A5_A5A5};
        rd = 1'b1; wr = 1'b1; req_ready = 1'b0;
        tick();
        if ({req_valid, req} !== {1'b1, 7'h22, 2'b10, 32'hA5A5_A5A5}) begin
            n_err++; $display("FAIL both_strobes_write: got %b/%h expected 1/%h", req_valid, req,
                              {7'h22, 2'b10, 32'hA5A5_A5A5});
        end
        n_vec++;
        #3 rst = 1'b1;
        #1;
        if ({req_valid, req} !== {1'b0, 41'h0}) begin
            n_err++; $display("FAIL async_reset: got %b/%h expected 0/0", req_valid, req);
        end
        n_vec++;
        #1 rd = 1'b0; wr = 1'b0;
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        int   cnt;
        logic gd;
        dmi_in = {7'h05, 2'b00, 32'h0};
        rd = 1'b1; req_ready = 1'b0; resp_valid = 1'b0;
        tick();
        cnt = 0;
        while (req_valid && cnt < 40) begin
            cnt++;
            tick();
        end
        if (cnt !== T) begin n_err++; $display("FAIL timeout_valid_cycles: got %0d expected %0d", cnt, T); end
        n_vec++;
        if ({done, err, resp_ready} !== 4'b1110) begin
            n_err++; $display("FAIL timeout_done_err: got %b expected 1110", {done, err, resp_ready});
        end
        n_vec++;
        if (dmi_out !== {7'h0, 32'h0, 2'b11}) begin
            n_err++; $display("FAIL timeout_dmi_o: got %h expected %h", dmi_out, {7'h0, 32'h0, 2'b11});
        end
        n_vec++;
        rd = 1'b0;
        repeat (2) tick();
        run_op(1'b0, {7'h11, 2'b00, 32'h0}, {32'h1234_5678, 2'b00}, gd);
        if ({gd, err} !== 3'b111) begin n_err++; $display("FAIL timeout_sticky_ok: got %b expected 111", {gd, err}); end
        n_vec++;
        if (dmi_out !== {7'h0, 32'h1234_5678, 2'b00}) begin
            n_err++; $display("FAIL timeout_next_read: got %h expected %h", dmi_out, {7'h0, 32'h1234_5678, 2'b00});
        end
        n_vec++;
        run_op(1'b0, {7'h11, 2'b00, 32'h0}, {32'h0, 2'b10}, gd);
        if ({gd, err} !== 3'b111) begin n_err++; $display("FAIL timeout_no_downgrade: got %b expected 111", {gd, err}); end
        n_vec++;
    endtask

    task automatic test_failed_resp;
        logic gd;
        hard = 1'b1; tick(); hard = 1'b0; tick();
        if (err !== 2'b00) begin n_err++; $display("FAIL hard_clears_busy: got %b expected 00", err); end
        n_vec++;
        run_op(1'b0, {7'h12, 2'b00, 32'h0}, {32'hBAD0_0000, 2'b10}, gd);
        if ({gd, err} !== 3'b110) begin n_err++; $display("FAIL failed_err: got %b expected 110", {gd, err}); end
        n_vec++;
        run_op(1'b1, {7'h13, 2'b00, 32'h7}, {32'h0000_0042, 2'b00}, gd);
        if ({gd, err} !== 3'b110) begin n_err++; $display("FAIL failed_sticky: got %b expected 110", {gd, err}); end
        n_vec++;
        hard = 1'b1; tick(); hard = 1'b0; tick();
        if (err !== 2'b00) begin n_err++; $display("FAIL hard_clears_failed: got %b expected 00", err); end
        n_vec++;
        if (dmi_out !== {7'h0, 32'h0000_0042, 2'b00}) begin
            n_err++; $display("FAIL hard_holds_dmi_o: got %h expected %h", dmi_out, {7'h0, 32'h42, 2'b00});
        end
        n_vec++;
    endtask

    task automatic test_hard_reset_mid_resp;
        int   bad;
        logic gd;
        dmi_in = {7'h33, 2'b00, 32'h0};
        rd = 1'b1; req_ready = 1'b1; resp_valid = 1'b0;
        repeat (2) tick();
        if (resp_ready !== 1'b1) begin n_err++; $display("FAIL hr_in_resp: got %b expected 1", resp_ready); end
        n_vec++;
        req_ready = 1'b0;
        tick();
        hard = 1'b1;
        tick();
        if ({resp_ready, done, req_valid} !== 3'b000) begin
            n_err++; $display("FAIL hr_abort: got %b expected 000", {resp_ready, done, req_valid});
        end
        n_vec++;
        bad = 0;
        repeat (3) begin
            tick();
            if (done || req_valid) bad++;
        end
        if (bad !== 0) begin n_err++; $display("FAIL hr_ignores_strobe: got %0d active cycles expected 0", bad); end
        n_vec++;
        hard = 1'b0; rd = 1'b0;
        tick();
        run_op(1'b0, {7'h34, 2'b00, 32'h0}, {32'h1357_9BDF, 2'b00}, gd);
        if ({gd, dmi_out} !== {1'b1, 7'h0, 32'h1357_9BDF, 2'b00}) begin
            n_err++; $display("FAIL hr_next_read: got %b/%h expected 1/%h", gd, dmi_out, {7'h0, 32'h1357_9BDF, 2'b00});
        end
        n_vec++;
    endtask

    task automatic test_timeout_race;
        dmi_in = {7'h01, 2'b00, 32'h0};
        rd = 1'b1; req_ready = 1'b0; resp_valid = 1'b0;
        tick();
        repeat (T - 1) tick();
        if (req_valid !== 1'b1) begin n_err++; $display("FAIL race_valid_last: got %b expected 1", req_valid); end
        n_vec++;
        req_ready = 1'b1;
        tick();
        if ({req_valid, resp_ready, done} !== 3'b010) begin
            n_err++; $display("FAIL race_req_wins: got %b expected 010", {req_valid, resp_ready, done});
        end
        n_vec++;
        req_ready = 1'b0; resp_valid = 1'b1; resp = {32'h2468_ACE0, 2'b00};
        tick();
        if ({done, err, dmi_out} !== {1'b1, 2'b00, 7'h0, 32'h2468_ACE0, 2'b00}) begin
            n_err++; $display("FAIL race_resp_wins: got %b/%b/%h expected 1/00/%h", done, err, dmi_out,
                              {7'h0, 32'h2468_ACE0, 2'b00});
        end
        n_vec++;
        rd = 1'b0; resp_valid = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        rst = 1'b1; hard = 1'b0; rd = 1'b0; wr = 1'b0;
        dmi_in = '0; req_ready = 1'b0; resp = '0; resp_valid = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_simultaneous_async_reset();
        test_timeout();
        test_failed_resp();
        test_hard_reset_mid_resp();
        test_timeout_race();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
